// File: rtl/swan_pkg.sv
// Shared constants and types for the SWAN vartheta diffusion layer.
package swan_pkg;

    localparam int SWAN_BLOCK_SIZE  = 64;
    localparam int SWAN_SIDE_SIZE   = SWAN_BLOCK_SIZE / 2;
    localparam int SWAN_COLUMN_SIZE = SWAN_SIDE_SIZE / 4;
    localparam int SWAN_NUM_COLUMNS = 4;

    // Left rotation (toward bit 0, the MSB) applied to each column, column 0 first.
    localparam int SWAN_THETA_ROT [0:SWAN_NUM_COLUMNS-1] = '{1, 6, 7, 0};

    // Half-block word, bit 0 is the most significant bit.
    typedef logic [0:SWAN_SIDE_SIZE-1] theta_word_t;

endpackage

// File: rtl/swan_col_rot.sv
// Combinational rotation of one column. dir=0 rotates toward bit 0 (left),
// dir=1 rotates the other way, undoing the forward map.
module swan_col_rot #(
    parameter int COLUMN_SIZE = 8,
    parameter int ROT_W       = $clog2(COLUMN_SIZE)
) (
    input  logic [ROT_W-1:0]       rot,
    input  logic                   dir,
    input  logic [0:COLUMN_SIZE-1] i,
    output logic [0:COLUMN_SIZE-1] o
);

    // Output bit j takes input bit (j +/- rot) mod COLUMN_SIZE; the index wraps
    // naturally because COLUMN_SIZE is a power of two.
    always_comb begin
        logic [ROT_W-1:0] idx;
        o   = '0;
        idx = '0;
        for (int j = 0; j < COLUMN_SIZE; j++) begin
            if (!dir) begin
                idx = ROT_W'(j) + rot;
            end else begin
                idx = ROT_W'(j) - rot;
            end
            o[j] = i[idx];
        end
    end

endmodule

// File: rtl/swan_vartheta.sv
// SWAN vartheta layer for one Feistel half: per-column bit rotation with a
// registered output and a one-cycle valid.
module swan_vartheta
    import swan_pkg::*;
#(
    parameter int BLOCK_SIZE  = 64,
    parameter int SIDE_SIZE   = BLOCK_SIZE / 2,
    parameter int COLUMN_SIZE = SIDE_SIZE / 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 inv,
    input  logic [0:SIDE_SIZE-1] x,
    output logic                 out_valid,
    output logic [0:SIDE_SIZE-1] y
);

    localparam int ROT_W = (COLUMN_SIZE > 1) ? $clog2(COLUMN_SIZE) : 1;

    // Only the 32-bit half with 8-bit columns is supported.
    generate
        if (SIDE_SIZE != SWAN_SIDE_SIZE || COLUMN_SIZE != SWAN_COLUMN_SIZE ||
            BLOCK_SIZE != 2 * SIDE_SIZE) begin : g_bad_size
            $error("swan_vartheta: only SIDE_SIZE=32 / COLUMN_SIZE=8 is supported");
        end
    endgenerate

    logic [0:SIDE_SIZE-1] map_w;
    logic [0:SIDE_SIZE-1] y_d, y_q;
    logic                 out_valid_d, out_valid_q;

    // One rotator per column; columns never exchange bits.
    generate
        for (genvar gi = 0; gi < SWAN_NUM_COLUMNS; gi++) begin : g_col
            swan_col_rot #(
                .COLUMN_SIZE (COLUMN_SIZE),
                .ROT_W       (ROT_W)
            ) u_col_rot (
                .rot (ROT_W'(SWAN_THETA_ROT[gi])),
                .dir (inv),
                .i   (x[gi*COLUMN_SIZE +: COLUMN_SIZE]),
                .o   (map_w[gi*COLUMN_SIZE +: COLUMN_SIZE])
            );
        end
    endgenerate

    // Capture a new result on a transfer, otherwise hold y and drop valid.
    always_comb begin
        y_d         = y_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            y_d = map_w;
        end
    end

    // Output register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_swan_vartheta.sv
// Scoreboard bench for swan_vartheta: the driver pushes expected words, a
// monitor pops and compares whenever out_valid is seen.
module tb_swan_vartheta;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        inv;
    logic [31:0] x;
    logic        out_valid;
    logic [31:0] y;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];

    swan_vartheta dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .inv       (inv),
        .x         (x),
        .out_valid (out_valid),
        .y         (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: conventional MSB-first byte rotations.
    function automatic logic [31:0] ref_map(input logic [31:0] w, input logic dir);
        int          rots [4];
        logic [31:0] r;
        logic [7:0]  b;
        logic [7:0]  nb;
        int          s;
        rots = '{1, 6, 7, 0};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            b = w[31-8*c -: 8];
            s = dir ? ((8 - rots[c]) % 8) : rots[c];
            if (s == 0) nb = b;
            else        nb = (b << s) | (b >> (8 - s));
            r[31-8*c -: 8] = nb;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    task automatic send(input logic [31:0] w, input logic dir, input logic [31:0] e);
        @(negedge clk);
        in_valid = 1'b1;
        x        = w;
        inv      = dir;
        exp_q.push_back(e);
        $display("send x=%08h inv=%0d expect=%08h", w, dir, e);
    endtask

    // Monitor: out_valid must follow the transfer sampled at the edge, and
    // every valid result is compared against the oldest expected word.
    initial begin
        logic        want_valid;
        logic [31:0] e;
        forever begin
            @(posedge clk);
            want_valid = rst_n && in_valid;
            #1;
            checks++;
            if (out_valid !== want_valid) begin
                errors++;
                $display("FAIL out_valid_timing: got %0b expected %0b", out_valid, want_valid);
            end
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %08h expected no output", y);
                end else begin
                    e = exp_q.pop_front();
                    check("result", y, e);
                end
            end
        end
    end

    typedef struct {
        logic [31:0] xv;
        logic        dir;
        logic [31:0] ev;
    } vec_t;

    initial begin
        vec_t        vecs [10];
        logic [31:0] a;
        logic [31:0] fa;
        int          waited;

        vecs = '{
            '{32'h0000_0000, 1'b0, 32'h0000_0000},
            '{32'h0000_0000, 1'b1, 32'h0000_0000},
            '{32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF},
            '{32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF},
            '{32'h8000_0000, 1'b0, 32'h0100_0000},
            '{32'h0080_0000, 1'b0, 32'h0020_0000},
            '{32'h0000_8000, 1'b0, 32'h0000_4000},
            '{32'h0000_0080, 1'b0, 32'h0000_0080},
            '{32'hF095_1A12, 1'b1, 32'h7856_3412},
            '{32'h7856_3412, 1'b0, 32'hF095_1A12}
        };

        in_valid = 1'b0;
        inv      = 1'b0;
        x        = '0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset_y", y, 32'h0);
        check("reset_valid", {31'b0, out_valid}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, back to back.
        foreach (vecs[k]) send(vecs[k].xv, vecs[k].dir, vecs[k].ev);

        // Idle cycle: valid drops, y holds the last result.
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        check("hold_y", y, 32'hF095_1A12);
        check("hold_valid", {31'b0, out_valid}, 32'h0);

        // Streaming: forward a random word, then invert its image back.
        for (int n = 0; n < 500; n++) begin
            a  = $urandom;
            fa = ref_map(a, 1'b0);
            send(a, 1'b0, fa);
            send(fa, 1'b1, a);
        end

        // Reset between edges with a transfer pending.
        send($urandom, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_y", y, 32'h0);
        check("midreset_valid", {31'b0, out_valid}, 32'h0);
        exp_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        send(32'h7856_3412, 1'b0, 32'hF095_1A12);
        @(negedge clk);
        in_valid = 1'b0;

        // Drain with a bounded wait.
        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results expected 0", exp_q.size());
        end
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
